// File: rtl/tdd_frame_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// tdd_frame_sequencer_pkg
// Shared types and constants for the TDD frame sequencer.
//   state_t            : sequencer state encoding, also driven on tdd_state
//   WINDOW_INDEX_WIDTH : bits needed to index up to MAX_WINDOW_COUNT windows
//   CHANNEL_INDEX_WIDTH: bits needed to index up to MAX_CHANNEL_COUNT channels
// ----------------------------------------------------------------------------
package tdd_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WAITING = 2'd2,
        RUNNING = 2'd3
    } state_t;

    localparam int MAX_WINDOW_COUNT    = 8;
    localparam int WINDOW_INDEX_WIDTH  = 3;
    localparam int MAX_CHANNEL_COUNT   = 32;
    localparam int CHANNEL_INDEX_WIDTH = 5;

endpackage

// File: rtl/tdd_frame_sequencer_channel.sv
// ----------------------------------------------------------------------------
// tdd_frame_sequencer_channel
// One output channel: WINDOW_COUNT on/off windows compared against the frame
// counter, ORed, polarity-applied and registered.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   run            : sequencer is RUNNING and enabled; windows close otherwise
//   frame_wrap     : counter is at the last value of the frame this cycle
//   counter        : current frame counter
//   on_edges       : WINDOW_COUNT opening counter values, window 0 in the LSBs
//   off_edges      : WINDOW_COUNT closing counter values, same layout
//   ch_en, pol     : channel enable and idle polarity
//   level          : registered channel output
// ----------------------------------------------------------------------------
module tdd_frame_sequencer_channel
    import tdd_frame_sequencer_pkg::*;
#(
    parameter int   WINDOW_COUNT   = 2,
    parameter int   REGISTER_WIDTH = 32,
    parameter logic DEFAULT_LEVEL  = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   run,
    input  logic                                   frame_wrap,
    input  logic [REGISTER_WIDTH-1:0]              counter,
    input  logic [WINDOW_COUNT*REGISTER_WIDTH-1:0] on_edges,
    input  logic [WINDOW_COUNT*REGISTER_WIDTH-1:0] off_edges,
    input  logic                                   ch_en,
    input  logic                                   pol,
    output logic                                   level
);

    logic [WINDOW_COUNT-1:0] win_r;
    logic [WINDOW_COUNT-1:0] win_s;
    logic                    level_r;

    // Next window state: a close (off match, frame wrap, not running) beats an open.
    always_comb begin
        win_s = win_r;
        for (int w = 0; w < WINDOW_COUNT; w++) begin
            if (!run || frame_wrap) begin
                win_s[w] = 1'b0;
            end else if (counter == off_edges[w*REGISTER_WIDTH +: REGISTER_WIDTH]) begin
                win_s[w] = 1'b0;
            end else if (counter == on_edges[w*REGISTER_WIDTH +: REGISTER_WIDTH]) begin
                win_s[w] = 1'b1;
            end else begin
                win_s[w] = win_r[w];
            end
        end
    end

    // Window state and output register; the output follows the window one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r   <= '0;
            level_r <= DEFAULT_LEVEL;
        end else begin
            win_r <= win_s;
            if (ch_en) begin
                level_r <= (|win_s) ^ pol;
            end else begin
                level_r <= pol;
            end
        end
    end

    assign level = level_r;

endmodule

// File: rtl/tdd_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tdd_frame_sequencer
// TDD frame timing generator: after a sync it waits a start-up delay, then runs
// frames of a programmable length, opening per-channel on/off windows, for a
// burst of frames (0 = forever).
// Optional feature macro: TDD_FRAME_SEQUENCER_SHADOW_EN
//   defined   : cfg_* captured on cfg_commit into a pending set, applied in
//               IDLE/ARMED or at the next frame wrap; cfg_pending reports it.
//   undefined : cfg_* used directly, cfg_commit ignored, cfg_pending = 0.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   enable, sync             : run enable, single-cycle start trigger
//   cfg_frame_length         : frame length in cycles (0 = 2^REGISTER_WIDTH)
//   cfg_startup_delay        : cycles between sync and the first frame
//   cfg_burst_count          : frames per burst (0 = infinite)
//   cfg_on, cfg_off          : window edges, channel-major, window-minor
//   cfg_ch_en, cfg_pol       : per-channel enable and idle polarity
//   cfg_commit, cfg_pending  : shadow update request / not yet applied
//   tdd_channel, tdd_active  : channel outputs, WAITING-or-RUNNING flag
//   tdd_counter, tdd_state   : current counter and state
//   frame_end                : one-cycle pulse after the last cycle of a frame
// ----------------------------------------------------------------------------
module tdd_frame_sequencer
    import tdd_frame_sequencer_pkg::*;
#(
    parameter int                       CHANNEL_COUNT     = 8,
    parameter int                       WINDOW_COUNT      = 2,
    parameter int                       REGISTER_WIDTH    = 32,
    parameter int                       BURST_COUNT_WIDTH = 32,
    parameter logic [CHANNEL_COUNT-1:0] DEFAULT_POLARITY  = '0
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                enable,
    input  logic                                                sync,
    input  logic [REGISTER_WIDTH-1:0]                           cfg_frame_length,
    input  logic [REGISTER_WIDTH-1:0]                           cfg_startup_delay,
    input  logic [BURST_COUNT_WIDTH-1:0]                        cfg_burst_count,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] cfg_on,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] cfg_off,
    input  logic [CHANNEL_COUNT-1:0]                            cfg_ch_en,
    input  logic [CHANNEL_COUNT-1:0]                            cfg_pol,
    input  logic                                                cfg_commit,
    output logic                                                cfg_pending,
    output logic [CHANNEL_COUNT-1:0]                            tdd_channel,
    output logic                                                tdd_active,
    output logic [REGISTER_WIDTH-1:0]                           tdd_counter,
    output state_t                                              tdd_state,
    output logic                                                frame_end
);

    localparam int CH_EDGE_W = WINDOW_COUNT * REGISTER_WIDTH;
    localparam int EDGE_W    = CHANNEL_COUNT * CH_EDGE_W;
    localparam int CFG_W     = 2*REGISTER_WIDTH + BURST_COUNT_WIDTH + 2*EDGE_W + 2*CHANNEL_COUNT;
    // Active set after reset: all timing zero, channels disabled, idle polarity.
    localparam logic [CFG_W-1:0] CFG_RESET = {{(CFG_W-CHANNEL_COUNT){1'b0}}, DEFAULT_POLARITY};

    // Whole configuration handled as one bus so the shadow path is a plain register copy.
    logic [CFG_W-1:0]             cfg_bus_s;
    logic [CFG_W-1:0]             act_bus_s;
    logic [REGISTER_WIDTH-1:0]    act_frame_length_s;
    logic [REGISTER_WIDTH-1:0]    act_startup_delay_s;
    logic [BURST_COUNT_WIDTH-1:0] act_burst_count_s;
    logic [EDGE_W-1:0]            act_on_s;
    logic [EDGE_W-1:0]            act_off_s;
    logic [CHANNEL_COUNT-1:0]     act_ch_en_s;
    logic [CHANNEL_COUNT-1:0]     act_pol_s;

    state_t                       state_r;
    state_t                       state_s;
    logic [REGISTER_WIDTH-1:0]    counter_r;
    logic [REGISTER_WIDTH-1:0]    counter_s;
    logic [BURST_COUNT_WIDTH-1:0] burst_cnt_r;
    logic [BURST_COUNT_WIDTH-1:0] burst_cnt_s;
    logic [BURST_COUNT_WIDTH-1:0] burst_next_s;
    logic                         frame_end_r;
    logic                         frame_end_s;
    logic                         active_r;
    logic [REGISTER_WIDTH-1:0]    frame_last_s;
    logic [REGISTER_WIDTH-1:0]    delay_last_s;
    logic                         frame_wrap_s;
    logic                         run_s;

    assign cfg_bus_s = {cfg_frame_length, cfg_startup_delay, cfg_burst_count,
                        cfg_on, cfg_off, cfg_ch_en, cfg_pol};
    assign {act_frame_length_s, act_startup_delay_s, act_burst_count_s,
            act_on_s, act_off_s, act_ch_en_s, act_pol_s} = act_bus_s;

    // Length 0 makes frame_last all ones, i.e. a full 2^REGISTER_WIDTH frame.
    assign frame_last_s = act_frame_length_s - REGISTER_WIDTH'(1);
    assign delay_last_s = act_startup_delay_s - REGISTER_WIDTH'(1);
    assign frame_wrap_s = (state_r == RUNNING) && (counter_r == frame_last_s);
    assign burst_next_s = burst_cnt_r + BURST_COUNT_WIDTH'(1);
    assign run_s        = enable && (state_r == RUNNING);

`ifdef TDD_FRAME_SEQUENCER_SHADOW_EN
    logic [CFG_W-1:0] pend_bus_r;
    logic [CFG_W-1:0] act_bus_r;
    logic             pending_r;
    logic             apply_s;

    assign apply_s = pending_r &&
                     ((state_r == IDLE) || (state_r == ARMED) || frame_wrap_s);

    // Pending/active configuration; a commit coinciding with an apply refills pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_bus_r <= CFG_RESET;
            act_bus_r  <= CFG_RESET;
            pending_r  <= 1'b0;
        end else begin
            if (cfg_commit) begin
                pend_bus_r <= cfg_bus_s;
            end
            if (apply_s) begin
                act_bus_r <= pend_bus_r;
            end
            if (cfg_commit) begin
                pending_r <= 1'b1;
            end else if (apply_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign act_bus_s   = act_bus_r;
    assign cfg_pending = pending_r;
`else
    logic unused_commit_s;

    assign unused_commit_s = cfg_commit;
    assign act_bus_s       = cfg_bus_s;
    assign cfg_pending     = 1'b0;
`endif

    // Next-state, counter, burst and frame_end decisions; enable low overrides all.
    always_comb begin
        state_s     = state_r;
        counter_s   = counter_r;
        burst_cnt_s = burst_cnt_r;
        frame_end_s = 1'b0;
        if (!enable) begin
            state_s   = IDLE;
            counter_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s   = ARMED;
                    counter_s = '0;
                end
                ARMED: begin
                    counter_s = '0;
                    if (sync) begin
                        burst_cnt_s = '0;
                        if (act_startup_delay_s != '0) begin
                            state_s = WAITING;
                        end else begin
                            state_s = RUNNING;
                        end
                    end else begin
                        state_s = ARMED;
                    end
                end
                WAITING: begin
                    if (counter_r == delay_last_s) begin
                        state_s   = RUNNING;
                        counter_s = '0;
                    end else begin
                        counter_s = counter_r + REGISTER_WIDTH'(1);
                    end
                end
                RUNNING: begin
                    if (frame_wrap_s) begin
                        counter_s   = '0;
                        frame_end_s = 1'b1;
                        burst_cnt_s = burst_next_s;
                        if ((act_burst_count_s != '0) && (burst_next_s == act_burst_count_s)) begin
                            state_s = ARMED;
                        end else begin
                            state_s = RUNNING;
                        end
                    end else begin
                        counter_s = counter_r + REGISTER_WIDTH'(1);
                    end
                end
                default: begin
                    state_s   = IDLE;
                    counter_s = '0;
                end
            endcase
        end
    end

    // Sequencer registers, including registered frame_end and tdd_active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            counter_r   <= '0;
            burst_cnt_r <= '0;
            frame_end_r <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            counter_r   <= counter_s;
            burst_cnt_r <= burst_cnt_s;
            frame_end_r <= frame_end_s;
            active_r    <= (state_s == WAITING) || (state_s == RUNNING);
        end
    end

    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_channel
        tdd_frame_sequencer_channel #(
            .WINDOW_COUNT   (WINDOW_COUNT),
            .REGISTER_WIDTH (REGISTER_WIDTH),
            .DEFAULT_LEVEL  (DEFAULT_POLARITY[c])
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .run        (run_s),
            .frame_wrap (frame_wrap_s),
            .counter    (counter_r),
            .on_edges   (act_on_s[c*CH_EDGE_W +: CH_EDGE_W]),
            .off_edges  (act_off_s[c*CH_EDGE_W +: CH_EDGE_W]),
            .ch_en      (act_ch_en_s[c]),
            .pol        (act_pol_s[c]),
            .level      (tdd_channel[c])
        );
    end

    assign tdd_active  = active_r;
    assign tdd_counter = counter_r;
    assign tdd_state   = state_r;
    assign frame_end   = frame_end_r;

endmodule

// File: tb/tb_tdd_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tdd_frame_sequencer
// Self-checking bench for tdd_frame_sequencer (small instance: 4 channels,
// 2 windows, 8-bit timing, 4-bit burst). Expected behaviour is computed from
// the elapsed cycles since sync with plain arithmetic on the configuration.
// Build with TDD_FRAME_SEQUENCER_SHADOW_EN to also exercise the shadow path.
// ----------------------------------------------------------------------------
module tb_tdd_frame_sequencer;

    localparam int NC = 4;
    localparam int NW = 2;
    localparam int RW = 8;
    localparam int BW = 4;
    localparam logic [NC-1:0] DEF_POL = 4'b1010;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_WAITING = 2'd2;
    localparam logic [1:0] S_RUNNING = 2'd3;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                sync;
    logic [RW-1:0]       cfg_frame_length;
    logic [RW-1:0]       cfg_startup_delay;
    logic [BW-1:0]       cfg_burst_count;
    logic [NC*NW*RW-1:0] cfg_on;
    logic [NC*NW*RW-1:0] cfg_off;
    logic [NC-1:0]       cfg_ch_en;
    logic [NC-1:0]       cfg_pol;
    logic                cfg_commit;
    logic                cfg_pending;
    logic [NC-1:0]       tdd_channel;
    logic                tdd_active;
    logic [RW-1:0]       tdd_counter;
    logic [1:0]          tdd_state;
    logic                frame_end;

    int n_checks = 0;
    int n_errors = 0;

    // Configuration as the bench sees it.
    int       cf_len;
    int       cf_delay;
    int       cf_burst;
    int       cf_on  [NC][NW];
    int       cf_off [NC][NW];
    bit [NC-1:0] cf_en;
    bit [NC-1:0] cf_pol;

    tdd_frame_sequencer #(
        .CHANNEL_COUNT     (NC),
        .WINDOW_COUNT      (NW),
        .REGISTER_WIDTH    (RW),
        .BURST_COUNT_WIDTH (BW),
        .DEFAULT_POLARITY  (DEF_POL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .sync              (sync),
        .cfg_frame_length  (cfg_frame_length),
        .cfg_startup_delay (cfg_startup_delay),
        .cfg_burst_count   (cfg_burst_count),
        .cfg_on            (cfg_on),
        .cfg_off           (cfg_off),
        .cfg_ch_en         (cfg_ch_en),
        .cfg_pol           (cfg_pol),
        .cfg_commit        (cfg_commit),
        .cfg_pending       (cfg_pending),
        .tdd_channel       (tdd_channel),
        .tdd_active        (tdd_active),
        .tdd_counter       (tdd_counter),
        .tdd_state         (tdd_state),
        .frame_end         (frame_end)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_len();
        return (cf_len == 0) ? (1 << RW) : cf_len;
    endfunction

    // Is any window of channel c open after the counter value j was processed?
    function automatic bit win_open(int c, int j);
        bit o = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (cf_on[c][w] != cf_off[c][w] && cf_on[c][w] <= j &&
                (cf_off[c][w] < cf_on[c][w] || j < cf_off[c][w])) o = 1'b1;
        end
        return o;
    endfunction

    // Expected outputs d clock edges after the edge that accepted sync.
    task automatic model_at(input int d, output logic [1:0] st, output int cnt,
                            output logic fe, output logic [NC-1:0] ch);
        int len = eff_len();
        int r;
        ch = cf_pol;
        fe = 1'b0;
        if (d < cf_delay) begin
            st  = S_WAITING;
            cnt = d;
        end else begin
            r = d - cf_delay;
            if (cf_burst != 0 && r >= cf_burst * len) begin
                st  = S_ARMED;
                cnt = 0;
                fe  = (r == cf_burst * len);
            end else begin
                st  = S_RUNNING;
                cnt = r % len;
                fe  = (r > 0) && (cnt == 0);
                for (int c = 0; c < NC; c++) begin
                    if (cf_en[c] && cnt >= 1 && win_open(c, cnt - 1)) ch[c] = ~cf_pol[c];
                end
            end
        end
    endtask

    task automatic compare_cycle(input string tag, input logic [1:0] st, input int cnt,
                                 input logic fe, input logic [NC-1:0] ch, input logic pend);
        check_value({tag, ".state"},   32'(tdd_state),   32'(st));
        check_value({tag, ".counter"}, 32'(tdd_counter), 32'(cnt));
        check_value({tag, ".active"},  32'(tdd_active),  32'((st == S_WAITING) || (st == S_RUNNING)));
        check_value({tag, ".fend"},    32'(frame_end),   32'(fe));
        check_value({tag, ".chan"},    32'(tdd_channel), 32'(ch));
        check_value({tag, ".pend"},    32'(cfg_pending), 32'(pend));
    endtask

    task automatic drive_config();
        cfg_frame_length  = RW'(cf_len);
        cfg_startup_delay = RW'(cf_delay);
        cfg_burst_count   = BW'(cf_burst);
        for (int c = 0; c < NC; c++) begin
            for (int w = 0; w < NW; w++) begin
                cfg_on[(c*NW + w)*RW +: RW]  = RW'(cf_on[c][w]);
                cfg_off[(c*NW + w)*RW +: RW] = RW'(cf_off[c][w]);
            end
        end
        cfg_ch_en = cf_en;
        cfg_pol   = cf_pol;
    endtask

    // Load the bench configuration while IDLE (enable low).
    task automatic load_config();
        drive_config();
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
`ifdef TDD_FRAME_SEQUENCER_SHADOW_EN
        check_value("load.pend_set", 32'(cfg_pending), 32'd1);
        @(negedge clk);
        check_value("load.pend_clr", 32'(cfg_pending), 32'd0);
`else
        check_value("load.pend_tied", 32'(cfg_pending), 32'd0);
        @(negedge clk);
`endif
        @(negedge clk);
    endtask

    task automatic arm(input int extra);
        enable = 1'b1;
        for (int i = 0; i <= extra; i++) begin
            @(negedge clk);
            compare_cycle("armed", S_ARMED, 0, 1'b0, cf_pol, 1'b0);
        end
    endtask

    task automatic go_idle();
        enable = 1'b0;
        @(negedge clk);
        compare_cycle("idle", S_IDLE, 0, 1'b0, cf_pol, 1'b0);
    endtask

    // Pulse sync from ARMED and follow n cycles; optional enable drop and stray sync.
    task automatic run_burst(input int n, input int drop_at, input int spur_at);
        logic [1:0]    st;
        int            cnt;
        logic          fe;
        logic [NC-1:0] ch;
        bit            dropped = 1'b0;
        sync = 1'b1;
        for (int d = 0; d < n; d++) begin
            @(negedge clk);
            sync = 1'b0;
            if (dropped) begin
                compare_cycle("drop", S_IDLE, 0, 1'b0, cf_pol, 1'b0);
            end else begin
                model_at(d, st, cnt, fe, ch);
                compare_cycle("run", st, cnt, fe, ch, 1'b0);
            end
            if (d == drop_at) begin
                enable  = 1'b0;
                dropped = 1'b1;
            end else if (d == spur_at && !dropped) begin
                sync = 1'b1;
            end
        end
        sync = 1'b0;
    endtask

    task automatic clear_windows();
        for (int c = 0; c < NC; c++) begin
            for (int w = 0; w < NW; w++) begin
                cf_on[c][w]  = 0;
                cf_off[c][w] = 0;
            end
        end
    endtask

    initial begin
        logic [1:0]    st;
        int            cnt;
        logic          fe;
        logic [NC-1:0] ch;
        int            total;

        rst = 1'b1; enable = 1'b0; sync = 1'b0; cfg_commit = 1'b0;
        cf_len = 10; cf_delay = 3; cf_burst = 2; cf_en = '0; cf_pol = '0;
        clear_windows();
        drive_config();
        repeat (3) @(negedge clk);
        check_value("rst.state",   32'(tdd_state),   32'(S_IDLE));
        check_value("rst.counter", 32'(tdd_counter), 32'd0);
        check_value("rst.chan",    32'(tdd_channel), 32'(DEF_POL));
        check_value("rst.active",  32'(tdd_active),  32'd0);
        check_value("rst.fend",    32'(frame_end),   32'd0);
        check_value("rst.pend",    32'(cfg_pending), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 10, delay 3, burst 2: ch0 2/5, ch1 1/3+6/8 inverted, ch2 on=off, ch3 disabled.
        cf_len = 10; cf_delay = 3; cf_burst = 2;
        clear_windows();
        cf_on[0][0] = 2; cf_off[0][0] = 5;
        cf_on[1][0] = 1; cf_off[1][0] = 3; cf_on[1][1] = 6; cf_off[1][1] = 8;
        cf_on[2][0] = 4; cf_off[2][0] = 4; cf_on[2][1] = 4; cf_off[2][1] = 4;
        cf_on[3][0] = 0; cf_off[3][0] = 5;
        cf_en = 4'b0111; cf_pol = 4'b1010;
        load_config();
        arm(1);
        run_burst(3 + 20 + 3, -1, 5);
        run_burst(3 + 20 + 3, -1, -1);
        go_idle();

        // Infinite burst, enable dropped at counter 7.
        cf_delay = 0; cf_burst = 0;
        load_config();
        arm(0);
        run_burst(12, 7, -1);

        // Frame length 0 means a full 2^RW counter period.
        cf_len = 0; cf_delay = 1; cf_burst = 1;
        clear_windows();
        cf_on[3][0] = 250; cf_off[3][0] = 3;
        cf_en = 4'b1000; cf_pol = 4'b0000;
        load_config();
        arm(0);
        run_burst(1 + 256 + 2, -1, -1);
        go_idle();

        // Reset in the middle of a frame, then clean restart.
        cf_len = 10; cf_delay = 0; cf_burst = 0;
        clear_windows();
        cf_on[0][0] = 2; cf_off[0][0] = 8;
        cf_en = 4'b0001; cf_pol = 4'b0100;
        load_config();
        arm(0);
        sync = 1'b1;
        for (int d = 0; d <= 6; d++) begin
            @(negedge clk);
            sync = 1'b0;
            model_at(d, st, cnt, fe, ch);
            compare_cycle("prerst", st, cnt, fe, ch, 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        check_value("midrst.state",   32'(tdd_state),   32'(S_IDLE));
        check_value("midrst.counter", 32'(tdd_counter), 32'd0);
        check_value("midrst.chan",    32'(tdd_channel), 32'(DEF_POL));
        check_value("midrst.active",  32'(tdd_active),  32'd0);
        check_value("midrst.fend",    32'(frame_end),   32'd0);
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        load_config();
        arm(0);
        run_burst(25, -1, -1);
        go_idle();

`ifdef TDD_FRAME_SEQUENCER_SHADOW_EN
        // Commit at counter 4: pending until frame_end, new edge only in the next frame.
        cf_len = 10; cf_delay = 0; cf_burst = 0;
        clear_windows();
        cf_on[0][0] = 2; cf_off[0][0] = 5;
        cf_en = 4'b0001; cf_pol = 4'b0000;
        load_config();
        arm(0);
        sync = 1'b1;
        for (int d = 0; d < 30; d++) begin
            @(negedge clk);
            sync = 1'b0;
            cfg_commit = 1'b0;
            if (d == 10) cf_on[0][0] = 1;
            model_at(d, st, cnt, fe, ch);
            compare_cycle("shadow", st, cnt, fe, ch, (d >= 5 && d <= 9));
            if (d == 4) begin
                cfg_on[0 +: RW] = RW'(1);
                cfg_commit      = 1'b1;
            end
        end
        go_idle();
`endif

        // Randomized scenarios.
        for (int it = 0; it < 25; it++) begin
            cf_len   = $urandom_range(1, 12);
            cf_delay = $urandom_range(0, 4);
            cf_burst = $urandom_range(0, 3);
            for (int c = 0; c < NC; c++) begin
                for (int w = 0; w < NW; w++) begin
                    cf_on[c][w]  = $urandom_range(0, cf_len);
                    cf_off[c][w] = $urandom_range(0, cf_len);
                end
            end
            cf_en  = NC'($urandom);
            cf_pol = NC'($urandom);
            load_config();
            arm($urandom_range(0, 2));
            if (cf_burst == 0) begin
                total = $urandom_range(15, 40);
                run_burst(total, $urandom_range(1, total - 2), $urandom_range(0, 10));
            end else begin
                total = cf_delay + cf_burst * cf_len;
                run_burst(total + 2, -1, $urandom_range(0, total - 1));
                run_burst(total + 2, ($urandom_range(0, 1) == 1) ? $urandom_range(0, total) : -1, -1);
            end
            go_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdd_frame_sequencer.md
TDD_FRAME_SEQUENCER -- requirements
Module: tdd_frame_sequencer

Interface
REQ-001 SHALL have parameter CHANNEL_COUNT, default 8: number of output channels, 1..32.
REQ-002 SHALL have parameter WINDOW_COUNT, default 2: on/off windows per channel, 1..8.
REQ-003 SHALL have parameter REGISTER_WIDTH, default 32: width of the counter and all timing values.
REQ-004 SHALL have parameter BURST_COUNT_WIDTH, default 32: width of the frame repetition count.
REQ-005 SHALL have parameter DEFAULT_POLARITY, default all zeros: per-channel idle level.
REQ-006 SHALL have a single clock: clk, in, 1 bit; every flop is clocked on its rising edge.
REQ-007 SHALL have reset rst, in, 1 bit: asynchronous, active-high.
REQ-008 SHALL have enable, in, 1 bit: the sequencer runs while high.
REQ-009 SHALL have sync, in, 1 bit: a single-cycle start trigger.
REQ-010 SHALL have cfg_frame_length, cfg_startup_delay (in, REGISTER_WIDTH each) and cfg_burst_count (in, BURST_COUNT_WIDTH).
REQ-011 SHALL have cfg_on and cfg_off, in, CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH each: window edges, flat, channel-major.
REQ-012 SHALL have cfg_ch_en and cfg_pol, in, CHANNEL_COUNT each: channel enable and polarity.
REQ-013 SHALL have cfg_commit, in, 1 bit: a pulse that requests a shadow update.
REQ-014 SHALL have cfg_pending, out, 1 bit: a committed update is not yet applied.
REQ-015 SHALL have outputs tdd_channel (CHANNEL_COUNT), tdd_active (1), tdd_counter (REGISTER_WIDTH), tdd_state (2, state_t) and frame_end (1, single-cycle pulse).

Function
REQ-016 SHALL implement the states IDLE, ARMED, WAITING and RUNNING.
REQ-017 SHALL move IDLE->ARMED when enable is high; from any state, enable low moves to IDLE on the next edge and clears the counter.
REQ-018 SHALL move ARMED->WAITING when sync is high and startup_delay!=0, or ARMED->RUNNING when sync is high and startup_delay==0; the counter is 0 on entry to either state.
REQ-019 SHALL, in WAITING, increment the counter each cycle and, when counter==startup_delay-1, move to RUNNING with the counter at 0.
REQ-020 SHALL, in RUNNING, increment the counter each cycle and, when counter==frame_length-1, pulse frame_end, wrap the counter to 0 and count the frame.
REQ-021 SHALL treat burst_count==0 as infinite frames; for burst N>0, after the Nth frame_end it moves to ARMED, and a new sync restarts the burst.
REQ-022 SHALL ignore sync while in WAITING or RUNNING.
REQ-023 SHALL treat frame_length==0 as frame_length==2^REGISTER_WIDTH, i.e. counter wrap-around.
REQ-024 SHALL drive tdd_active high exactly in WAITING and RUNNING.
REQ-025 SHALL, per window in RUNNING, open the window at counter==on and close it at counter==off; when on==off, off takes priority and the window stays closed.
REQ-026 SHALL close all windows on frame_end and whenever the sequencer is not in RUNNING.
REQ-027 SHALL drive tdd_channel[c] = (OR of the windows of c) XOR pol[c], registered, so an edge appears 1 cycle after the matching counter value.
REQ-028 SHALL hold tdd_channel[c] at pol[c] when ch_en[c]==0, with no glitch.
REQ-029 SHALL use no DSP multipliers; the counter and burst counter wrap modulo their widths.

Reset
REQ-030 SHALL, while rst is high, force state IDLE, counter 0, burst counter 0, all windows closed, tdd_channel=DEFAULT_POLARITY, tdd_active 0, frame_end 0 and cfg_pending 0.
REQ-031 SHALL reset the shadow (active) configuration to: timing values 0, ch_en all 0, pol=DEFAULT_POLARITY.
REQ-032 SHALL give reset mid-frame priority over every event in the same cycle.

Configuration
REQ-033 SHALL use the macro TDD_FRAME_SEQUENCER_SHADOW_EN.
REQ-034 SHALL, when the macro is defined, capture all cfg_* inputs into a pending set on cfg_commit and set cfg_pending.
REQ-035 SHALL, when the macro is defined, copy the pending set to the active set and clear cfg_pending in IDLE or ARMED on the next cycle, otherwise at the next frame_end (applied from counter 0 of the next frame).
REQ-036 SHALL, when the macro is defined, have a cfg_commit that coincides with an apply overwrite the pending set and leave cfg_pending high.
REQ-037 SHALL, when the macro is undefined, use the cfg_* inputs directly, ignore cfg_commit and tie cfg_pending to 0.

Structure
REQ-038 SHALL declare state_t (2-bit enum IDLE=0, ARMED=1, WAITING=2, RUNNING=3) and the window index width constants in the package tdd_frame_sequencer_pkg.
REQ-039 SHALL implement the per-channel window logic and output register in the sub-module tdd_frame_sequencer_channel, instantiated CHANNEL_COUNT times.

Verification
REQ-040 SHALL cover: frame 10, delay 3, burst 2, ch0 on=2/off=5, then sync -> ch0 high on cycles 3..5 after RUNNING entry in both frames, 2 frame_end pulses, then ARMED.
REQ-041 SHALL cover: ch1 windows 1/3 and 6/8, pol=1 -> ch1 low over counter 2..3 and 7..8, high otherwise.
REQ-042 SHALL cover: on=off=4 on ch2 -> ch2 stays at pol for the whole frame.
REQ-043 SHALL cover: burst 0, enable dropped at counter 7 -> IDLE next cycle, all outputs at pol, tdd_active 0.
REQ-044 SHALL cover, with SHADOW_EN: commit ch0 on=1 at counter 4 of a 10-cycle frame -> cfg_pending high until frame_end, new edge in the next frame only.
REQ-045 SHALL cover: rst asserted at counter 6 in RUNNING -> outputs equal DEFAULT_POLARITY and counter 0 immediately; enable and sync after release restart cleanly.
